// File: rtl/genbuf_sender.sv
// Sender side of the GenBuf four-phase REQ/ACK handshake: a small FIFO feeds
// words to the buffer, counts completed transfers and flags responder errors.
module genbuf_sender #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic              StoB_REQ,
  output logic [DATA_W-1:0] DI,
  input  logic              BtoS_ACK,
  output logic [CNT_W-1:0]  xfer_count,
  output logic [AW:0]       fifo_level,
  output logic              proto_err
);

  typedef enum logic [1:0] {IDLE, REQ, ACKWAIT} state_t;

  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              full, empty, push, pop;
  logic              req_nxt, err_set;
  logic [DATA_W-1:0] di_nxt;

  // The extra pointer bit makes the difference equal the occupancy directly.
  assign fifo_level = wr_ptr - rd_ptr;
  assign full       = (fifo_level == LVL_FULL);
  assign empty      = (fifo_level == '0);
  assign src_ready  = ~full;
  assign push       = src_valid & ~full;

  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a path
    // that skips an assignment infers a latch.
    state_nxt = state;
    req_nxt   = StoB_REQ;
    di_nxt    = DI;
    pop       = 1'b0;
    err_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (BtoS_ACK) begin
          err_set = 1'b1;
        end else if (!empty) begin
          req_nxt   = 1'b1;
          di_nxt    = mem[rd_ptr[AW-1:0]];
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (BtoS_ACK) begin
          req_nxt   = 1'b0;
          pop       = 1'b1;
          state_nxt = ACKWAIT;
        end
      end
      ACKWAIT: begin
        // Return-to-zero: no new request while the buffer still acknowledges.
        if (!BtoS_ACK) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      StoB_REQ   <= 1'b0;
      DI         <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      xfer_count <= '0;
      proto_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      StoB_REQ <= req_nxt;
      DI       <= di_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_ONE;
        xfer_count <= xfer_count + CNT_W'(1);
      end
      if (err_set) proto_err <= 1'b1;
    end
  end

  // NOTE: storage is not reset; flushing the pointers makes old contents
  // unreachable, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= src_data;
  end

endmodule

// File: tb/tb_genbuf_sender.sv
// Self-checking bench for genbuf_sender: vector table, directed handshake
// sequences and randomized traffic against a queue-based reference model.
module tb_genbuf_sender;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        src_valid = 1'b0;
  logic [7:0]  src_data = '0;
  logic        BtoS_ACK = 1'b0;
  logic        src_ready, StoB_REQ, proto_err;
  logic [7:0]  DI;
  logic [15:0] xfer_count;
  logic [2:0]  fifo_level;
  logic        src_ready2, req2, err2;
  logic [7:0]  di2;
  logic [1:0]  cnt2;
  logic [2:0]  lvl2;

  genbuf_sender #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .StoB_REQ(StoB_REQ), .DI(DI), .BtoS_ACK(BtoS_ACK),
    .xfer_count(xfer_count), .fifo_level(fifo_level), .proto_err(proto_err));

  genbuf_sender #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(2)) dut_w2 (
    .clock(clock), .reset_n(reset_n), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready2), .StoB_REQ(req2), .DI(di2), .BtoS_ACK(BtoS_ACK),
    .xfer_count(cnt2), .fifo_level(lvl2), .proto_err(err2));

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a word queue plus the handshake phase it is in.
  logic [7:0]  mq[$];
  bit          m_req, m_drain, m_err;
  logic [7:0]  m_di;
  logic [15:0] m_cnt;

  function automatic void model_reset();
    mq.delete();
    m_req = 0; m_drain = 0; m_err = 0; m_di = '0; m_cnt = '0;
  endfunction

  function automatic void model_edge(input bit v, input logic [7:0] d, input bit a);
    bit was_full;
    was_full = (mq.size() == DEPTH);
    if (m_req) begin
      if (a) begin
        m_req = 0;
        void'(mq.pop_front());
        m_cnt++;
        m_drain = 1;
      end
    end else if (m_drain) begin
      if (!a) m_drain = 0;
    end else if (a) begin
      m_err = 1;
    end else if (mq.size() != 0) begin
      m_req = 1;
      m_di  = mq[0];
    end
    if (v && !was_full) mq.push_back(d);
  endfunction

  task automatic check_model();
    check("m_req",   StoB_REQ,   m_req);
    check("m_di",    DI,         m_di);
    check("m_level", fifo_level, mq.size());
    check("m_ready", src_ready,  mq.size() < DEPTH);
    check("m_count", xfer_count, m_cnt);
    check("m_err",   proto_err,  m_err);
    check("m_cnt2",  cnt2,       m_cnt[1:0]);
  endtask

  bit         resp_prev, last_req;
  int         cyc, rise_with_ack;
  int         rise_cyc[$];
  logic [7:0] rise_di[$];

  // One clock: drive at negedge, model the edge, sample 1 ns after it.
  // use_resp selects a zero-wait responder: ACK = REQ now or one cycle ago.
  task automatic step(input bit v, input logic [7:0] d, input bit use_resp, input bit a_in);
    bit a;
    @(negedge clock);
    a = use_resp ? (StoB_REQ | resp_prev) : a_in;
    resp_prev = StoB_REQ;
    src_valid = v; src_data = d; BtoS_ACK = a;
    @(posedge clock);
    model_edge(v, d, a);
    cyc++;
    #1;
    check_model();
    if (StoB_REQ && !last_req) begin
      rise_cyc.push_back(cyc);
      rise_di.push_back(DI);
      if (a) rise_with_ack++;
    end
    last_req = StoB_REQ;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    src_valid = 1'b0; BtoS_ACK = 1'b0; resp_prev = 0; last_req = 0;
    model_reset();
    #1;
    check("rst_req", StoB_REQ, 0);
    check("rst_level", fifo_level, 0);
    @(negedge clock);
    reset_n = 1'b1;
    cyc = 0; rise_with_ack = 0;
    rise_cyc.delete(); rise_di.delete();
  endtask

  typedef struct {
    bit v; logic [7:0] d; bit a;
    bit e_req; logic [7:0] e_di; logic [2:0] e_lvl; logic [15:0] e_cnt; bit e_rdy; bit e_err;
  } vec_t;
  vec_t tbl[7];

  logic [7:0] words[5];
  bit         a_r;

  initial begin
    // Single word, responder acks one cycle after REQ, then a spurious ACK in IDLE.
    tbl[0] = '{1, 8'hA5, 0, 0, 8'h00, 1, 0, 1, 0};
    tbl[1] = '{0, 8'h00, 0, 1, 8'hA5, 1, 0, 1, 0};
    tbl[2] = '{0, 8'h00, 1, 0, 8'hA5, 0, 1, 1, 0};
    tbl[3] = '{0, 8'h00, 1, 0, 8'hA5, 0, 1, 1, 0};
    tbl[4] = '{0, 8'h00, 0, 0, 8'hA5, 0, 1, 1, 0};
    tbl[5] = '{0, 8'h00, 1, 0, 8'hA5, 0, 1, 1, 1};
    tbl[6] = '{0, 8'h00, 0, 0, 8'hA5, 0, 1, 1, 1};
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    do_reset();
    check("reset_cnt", xfer_count, 0);
    check("reset_err", proto_err, 0);
    check("reset_di", DI, 0);
    check("reset_ready", src_ready, 1);

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, 0, tbl[i].a);
      check($sformatf("vec%0d_req", i),   StoB_REQ,   tbl[i].e_req);
      check($sformatf("vec%0d_di", i),    DI,         tbl[i].e_di);
      check($sformatf("vec%0d_level", i), fifo_level, tbl[i].e_lvl);
      check($sformatf("vec%0d_cnt", i),   xfer_count, tbl[i].e_cnt);
      check($sformatf("vec%0d_ready", i), src_ready,  tbl[i].e_rdy);
      check($sformatf("vec%0d_err", i),   proto_err,  tbl[i].e_err);
    end

    // Fill with ACK held low: fifth word refused, DI pinned to the first word.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, words[i], 0, 0);
      if (i >= 1) check($sformatf("fill%0d_di", i), DI, 8'h11);
    end
    check("fill_level", fifo_level, 4);
    check("fill_ready", src_ready, 0);
    check("fill_req", StoB_REQ, 1);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0);
    check("fill_di_hold", DI, 8'h11);

    // Back-to-back with a zero-wait responder.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, words[i], 1, 0);
    for (int i = 0; i < 20; i++) step(0, 8'h00, 1, 0);
    check("b2b_rises", rise_cyc.size(), 4);
    check("b2b_count", xfer_count, 4);
    check("b2b_req_with_ack", rise_with_ack, 0);
    for (int i = 0; i < rise_di.size() && i < 4; i++)
      check($sformatf("b2b_di%0d", i), rise_di[i], words[i]);
    for (int i = 0; i + 1 < rise_cyc.size(); i++)
      check($sformatf("b2b_gap%0d", i), rise_cyc[i+1] - rise_cyc[i], 4);

    // Spurious ACK in IDLE with a word waiting.
    do_reset();
    step(1, 8'h3C, 0, 1);
    step(0, 8'h00, 0, 1);
    check("spur_err", proto_err, 1);
    check("spur_noreq", StoB_REQ, 0);
    step(0, 8'h00, 0, 0);
    check("spur_req", StoB_REQ, 1);
    check("spur_di", DI, 8'h3C);
    step(0, 8'h00, 0, 1);
    check("spur_cnt", xfer_count, 1);
    check("spur_sticky", proto_err, 1);

    // Reset asserted mid-REQ with three words queued.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, words[i], 1, 0);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    check("mid_pre_req", StoB_REQ, 1);
    check("mid_pre_level", fifo_level, 3);
    check("mid_pre_cnt", xfer_count, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_req", StoB_REQ, 0);
    check("mid_level", fifo_level, 0);
    check("mid_cnt", xfer_count, 0);
    check("mid_err", proto_err, 0);
    check("mid_di", DI, 0);
    do_reset();

    // Counter wrap on the 2-bit instance.
    for (int i = 0; i < 5; i++) step(1, words[i], 1, 0);
    for (int i = 0; i < 20; i++) step(0, 8'h00, 1, 0);
    check("wrap_cnt16", xfer_count, 5);
    check("wrap_cnt2", cnt2, 1);

    // Randomized traffic; the responder is mostly well-behaved.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (StoB_REQ)      a_r = ($urandom_range(0, 2) == 0);
      else if (BtoS_ACK) a_r = ($urandom_range(0, 1) == 0);
      else               a_r = ($urandom_range(0, 40) == 0);
      step(($urandom_range(0, 2) != 0), 8'($urandom), 0, a_r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
